// File: rtl/dm_pkg.sv
// Shared definitions for the data memory stage: access encodings and byte-enable helper.
package dm_pkg;

    typedef enum logic [2:0] {
        MEMOP_W  = 3'b000,
        MEMOP_HS = 3'b001,
        MEMOP_HU = 3'b010,
        MEMOP_BS = 3'b011,
        MEMOP_BU = 3'b100
    } memop_e;

    // Byte lanes touched by an access of the given width at the given byte offset.
    // Reserved encodings touch nothing.
    function automatic logic [3:0] byte_en(input logic [2:0] memop, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (memop)
            MEMOP_W:            be = 4'b1111;
            MEMOP_HS, MEMOP_HU: be = lane[1] ? 4'b1100 : 4'b0011;
            MEMOP_BS, MEMOP_BU: be = 4'b0001 << lane;
            default:            be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension; shared with the pipelined MEM stage.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  memop,
    output logic [31:0] rdata
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half   = lane[1] ? word[31:16] : word[15:0];
    assign byte_v = word[8*lane +: 8];

    // Pick the width, then extend; reserved encodings read as zero.
    always_comb begin
        rdata = 32'h0;
        case (memop)
            MEMOP_W:  rdata = word;
            MEMOP_HS: rdata = {{16{half[15]}}, half};
            MEMOP_HU: rdata = {16'h0, half};
            MEMOP_BS: rdata = {{24{byte_v[7]}}, byte_v};
            MEMOP_BU: rdata = {24'h0, byte_v};
            default:  rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// Data memory stage: byte-enabled stores on the clock edge, combinational
// extended loads, and address-error flags for the controller.
module dm_unit
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrite,
    input  logic [2:0]  memop,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Upper bound kept in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW+1:0] offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          misaligned;
    logic          reserved;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   ext_data;

    // Only the low AW+2 bits of the offset matter once the range check has passed.
    assign offset   = addr[AW+1:0] - ADDR_BASE[AW+1:0];
    assign word_idx = AW'(offset >> 2);

    assign in_range   = (addr >= ADDR_BASE) && ({1'b0, addr} < ADDR_END);
    assign reserved   = (memop > MEMOP_BU);
    assign misaligned = ((memop == MEMOP_W) && (addr[1:0] != 2'b00)) ||
                        (((memop == MEMOP_HS) || (memop == MEMOP_HU)) && addr[0]);
    assign err        = !in_range || misaligned || reserved;

    assign adel = err && !memwrite;
    assign ades = err && memwrite;

    assign be = byte_en(memop, addr[1:0]);

    // Replicate the store data so every enabled lane sees the right bytes.
    always_comb begin
        wlane = {4{wdata[7:0]}};
        if (memop == MEMOP_W)
            wlane = wdata;
        else if ((memop == MEMOP_HS) || (memop == MEMOP_HU))
            wlane = {2{wdata[15:0]}};
    end

    // Array: cleared asynchronously by reset, otherwise byte-enabled store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'h0;
        end else if (memwrite && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
        end
    end

    dm_load_ext u_load_ext (
        .word  (mem[word_idx]),
        .lane  (addr[1:0]),
        .memop (memop),
        .rdata (ext_data)
    );

    assign rdata = err ? 32'h0 : ext_data;

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit with hand-computed expected values.
module tb_dm_unit;
    import dm_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic [2:0]  memop;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;

    int n_checks = 0;
    int n_err    = 0;

    dm_unit dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .memwrite (memwrite),
        .memop    (memop),
        .rdata    (rdata),
        .adel     (adel),
        .ades     (ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store issued at a negedge, committed on the following posedge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        @(negedge clk);
        addr = a; wdata = d; memop = op; memwrite = 1'b1;
        @(posedge clk);
        #1 memwrite = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] op);
        memwrite = 1'b0; addr = a; memop = op;
        #1;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0; memop = MEMOP_W;
        repeat (2) @(posedge clk);
        // Error flags stay live during reset.
        do_load(32'h2, MEMOP_W);
        chk("adel_during_reset", {31'h0, adel}, 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Reset clear
        do_load(32'h0, MEMOP_W);   chk("rst_lw0", rdata, 32'h0);   chk("rst_adel0", {31'h0, adel}, 32'h0);
        do_load(32'h4, MEMOP_W);   chk("rst_lw4", rdata, 32'h0);
        do_load(32'hFFC, MEMOP_W); chk("rst_lwffc", rdata, 32'h0); chk("rst_adelffc", {31'h0, adel}, 32'h0);

        // Word round trip and extension
        do_store(32'h10, 32'hDEADBEEF, MEMOP_W);
        do_load(32'h10, MEMOP_W);  chk("lw10", rdata, 32'hDEADBEEF);
        do_load(32'h13, MEMOP_BU); chk("lbu13", rdata, 32'h0000_00DE);
        do_load(32'h13, MEMOP_BS); chk("lb13", rdata, 32'hFFFF_FFDE);
        do_load(32'h12, MEMOP_HU); chk("lhu12", rdata, 32'h0000_DEAD);
        do_load(32'h10, MEMOP_HS); chk("lh10", rdata, 32'hFFFF_BEEF);

        // Read-during-write: old contents until the edge
        @(negedge clk);
        addr = 32'h20; wdata = 32'h11223344; memop = MEMOP_W; memwrite = 1'b1;
        #1 chk("rdw_old", rdata, 32'h0);
        @(posedge clk);
        #1 chk("rdw_new", rdata, 32'h11223344);
        memwrite = 1'b0;

        // Partial stores: only low bits of wdata used, other bytes preserved
        do_store(32'h21, 32'hFFFF_FFAA, MEMOP_BU);
        do_load(32'h20, MEMOP_W);  chk("sb21", rdata, 32'h1122AA44);
        do_store(32'h22, 32'h1234_8001, MEMOP_HS);
        do_load(32'h20, MEMOP_W);  chk("sh22", rdata, 32'h8001AA44);
        do_load(32'h22, MEMOP_HS); chk("lh22", rdata, 32'hFFFF8001);
        do_load(32'h22, MEMOP_HU); chk("lhu22", rdata, 32'h00008001);
        do_load(32'h20, MEMOP_BS); chk("lb20", rdata, 32'h00000044);
        do_load(32'h21, MEMOP_BS); chk("lb21", rdata, 32'hFFFFFFAA);

        // Misalignment
        do_store(32'h04, 32'h0A0B0C0D, MEMOP_W);
        @(negedge clk);
        addr = 32'h06; wdata = 32'h99999999; memop = MEMOP_W; memwrite = 1'b1;
        #1 chk("ades_sw06", {31'h0, ades}, 32'h1);
        chk("adel_sw06", {31'h0, adel}, 32'h0);
        @(posedge clk);
        #1 memwrite = 1'b0;
        do_load(32'h04, MEMOP_W);  chk("w04_kept", rdata, 32'h0A0B0C0D);
        do_load(32'h05, MEMOP_HS); chk("adel_lh05", {31'h0, adel}, 32'h1); chk("rd_lh05", rdata, 32'h0);
        do_load(32'h05, MEMOP_BU); chk("adel_lb05", {31'h0, adel}, 32'h0); chk("rd_lb05", rdata, 32'h0000000C);
        do_load(32'h04, 3'b101);   chk("adel_rsvd", {31'h0, adel}, 32'h1); chk("rd_rsvd", rdata, 32'h0);

        // Range
        do_store(32'hFFC, 32'h13579BDF, MEMOP_W);
        do_load(32'h1000, MEMOP_W); chk("adel_1000", {31'h0, adel}, 32'h1); chk("rd_1000", rdata, 32'h0);
        do_load(32'hFFF, MEMOP_BU); chk("adel_fff", {31'h0, adel}, 32'h0); chk("rd_fff", rdata, 32'h00000013);
        @(negedge clk);
        addr = 32'hFFFF_FFFC; wdata = 32'hCAFEF00D; memop = MEMOP_W; memwrite = 1'b1;
        #1 chk("ades_wrap", {31'h0, ades}, 32'h1);
        @(posedge clk);
        #1 memwrite = 1'b0;
        do_load(32'hFFC, MEMOP_W); chk("lwffc_kept", rdata, 32'h13579BDF); chk("adel_ffc", {31'h0, adel}, 32'h0);

        // Async reset mid-cycle with a store pending
        do_store(32'h30, 32'h55, MEMOP_W);
        do_load(32'h30, MEMOP_W); chk("lw30", rdata, 32'h55);
        @(negedge clk);
        addr = 32'h30; wdata = 32'h77; memop = MEMOP_W; memwrite = 1'b1;
        #2 reset = 1'b1;
        #1 chk("async_clr", rdata, 32'h0);
        chk("ades_rst", {31'h0, ades}, 32'h0);
        @(posedge clk);
        #1 chk("store_dropped", rdata, 32'h0);
        memwrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_load(32'h30, MEMOP_W); chk("post_rst", rdata, 32'h0);

        // Reset released mid-cycle: next edge stores normally
        @(negedge clk);
        reset = 1'b1;
        addr = 32'h30; wdata = 32'h77; memop = MEMOP_W; memwrite = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1 chk("store_after_rel", rdata, 32'h77);
        memwrite = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
